// File: rtl/sdram_pkg.sv
// Shared SDRAM scheduling definitions: state encoding, refresh timing
// defaults and command strobe bit positions used by the command encoder.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_USER  = 3'd1,
    ST_PRECH = 3'd2,
    ST_TRP   = 3'd3,
    ST_AREF  = 3'd4,
    ST_TRFC  = 3'd5,
    ST_DONE  = 3'd6
  } sched_state_e;

  localparam int T_RP_DEF  = 3;
  localparam int T_RFC_DEF = 7;
  localparam int CW_DEF    = 4;

  // Bit positions in the command strobe vector
  localparam int CMD_PRE_ALL_IDX = 0;
  localparam int CMD_REF_IDX     = 1;
  localparam int CMD_W           = 2;

endpackage

// File: rtl/sdram_tmr.sv
// Loadable down-counter with zero / one flags; shared by the tRP and tRFC waits.
// Decrement saturates at zero.
module sdram_tmr #(
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero,
  output logic          one
);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && !zero)
      cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == CW'(1));

endmodule

// File: rtl/sdram_ref_sched.sv
// SDRAM command-bus scheduler: arbitrates user bursts against refresh and
// runs PRECHARGE ALL -> AUTO REFRESH. Optional DOUBLE_REF_EN issues two refreshes.
//
// state | meaning
// IDLE  | bus free, waiting for refresh or user request
// USER  | bus granted to user until user_done
// PRECH | PRECHARGE ALL strobe, tRP timer loaded
// TRP   | waiting out tRP
// AREF  | AUTO REFRESH strobe, tRFC timer loaded
// TRFC  | waiting out tRFC
// DONE  | clr_ref strobe, completion count bumped
module sdram_ref_sched
  import sdram_pkg::*;
#(
  parameter int T_RP  = T_RP_DEF,
  parameter int T_RFC = T_RFC_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        auto_ref,
  input  logic        p_auto_ref,
  input  logic        user_req,
  input  logic        user_done,
  output logic        user_gnt,
  output logic        cmd_pre_all,
  output logic        cmd_ref,
  output logic        clr_ref,
  output logic        ref_busy,
  output logic [15:0] ref_done_cnt
);

  localparam logic [CW-1:0] RP_LD  = CW'(T_RP - 1);
  localparam logic [CW-1:0] RFC_LD = CW'(T_RFC - 1);

  sched_state_e      state, state_nxt;
  logic              tmr_load, tmr_dec, tmr_zero, tmr_one, tmr_expire;
  logic [CW-1:0]     tmr_load_val;
  logic [CMD_W-1:0]  cmd_vec;
  logic              aref_last_in_aref, aref_last_in_trfc;

`ifdef DOUBLE_REF_EN
  // Toggles on every AREF: 1 between the first and second refresh of a sequence
  logic pass_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      pass_q <= 1'b0;
    else if (state == ST_AREF)
      pass_q <= ~pass_q;
  end

  assign aref_last_in_aref = pass_q;
  assign aref_last_in_trfc = ~pass_q;
`else
  assign aref_last_in_aref = 1'b1;
  assign aref_last_in_trfc = 1'b1;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Wait states exit on the decrement that lands the count at zero, so the
  // strobe spacing equals the full T_RP / T_RFC.
  assign tmr_expire = tmr_one || tmr_zero;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (auto_ref)
          state_nxt = ST_PRECH;
        else if (user_req && !p_auto_ref)
          state_nxt = ST_USER;
      end
      ST_USER: begin
        if (user_done)
          state_nxt = auto_ref ? ST_PRECH : ST_IDLE;
      end
      ST_PRECH: state_nxt = (T_RP == 1) ? ST_AREF : ST_TRP;
      ST_TRP: begin
        if (tmr_expire)
          state_nxt = ST_AREF;
      end
      ST_AREF: begin
        if (T_RFC == 1)
          state_nxt = aref_last_in_aref ? ST_DONE : ST_AREF;
        else
          state_nxt = ST_TRFC;
      end
      ST_TRFC: begin
        if (tmr_expire)
          state_nxt = aref_last_in_trfc ? ST_DONE : ST_AREF;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    user_gnt = 1'b0;
    cmd_vec  = '0;
    clr_ref  = 1'b0;
    ref_busy = 1'b0;
    case (state)
      ST_USER:  user_gnt = 1'b1;
      ST_PRECH: begin
        cmd_vec[CMD_PRE_ALL_IDX] = 1'b1;
        ref_busy = 1'b1;
      end
      ST_TRP:   ref_busy = 1'b1;
      ST_AREF: begin
        cmd_vec[CMD_REF_IDX] = 1'b1;
        ref_busy = 1'b1;
      end
      ST_TRFC:  ref_busy = 1'b1;
      ST_DONE: begin
        clr_ref  = 1'b1;
        ref_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_pre_all = cmd_vec[CMD_PRE_ALL_IDX];
  assign cmd_ref     = cmd_vec[CMD_REF_IDX];

  assign tmr_load     = (state == ST_PRECH) || (state == ST_AREF);
  assign tmr_load_val = (state == ST_AREF) ? RFC_LD : RP_LD;
  assign tmr_dec      = (state == ST_TRP) || (state == ST_TRFC);

  sdram_tmr #(.CW(CW)) u_tmr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .one      (tmr_one)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      ref_done_cnt <= 16'd0;
    else if (state == ST_DONE)
      ref_done_cnt <= ref_done_cnt + 16'd1;
  end

endmodule
